vec_mul_seq: RTL and testbench
==============================

VEC_MUL_SEQ -- requirements
Module: vec_mul_seq

Interface
REQ-001 Parameter bit_width, default 8: operand element width in bits.
REQ-002 Parameter length, default 32: number of elements per vector.
REQ-003 Parameter n_mul, default 8: number of physical multipliers; length SHALL be an integer multiple of n_mul, checked at elaboration.
REQ-004 Parameter prd_width, default 2*bit_width: product element width; prd_width < 2*bit_width SHALL fail elaboration.
REQ-005 Derived constant BEATS = length/n_mul: multiply cycles per vector.
REQ-006 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 i_rst  in  1  reset, synchronous, active-high.
REQ-008 i_valid  in  1  input vector offered.
REQ-009 o_ready  out  1  block can accept an input vector this cycle.
REQ-010 i_vec_a  in  length x bit_width  operand vector A.
REQ-011 i_vec_b  in  length x bit_width  operand vector B.
REQ-012 i_signed  in  1  1: two's-complement operands; 0: unsigned operands.
REQ-013 o_valid  out  1  product vector available.
REQ-014 i_ready  in  1  downstream accepts product vector.
REQ-015 o_prd  out  length x prd_width  elementwise product vector.

Function
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 Accept: handshake completes on a rising edge where i_valid and o_ready are both 1; i_vec_a, i_vec_b, i_signed are captured into internal registers at that edge only.
REQ-018 o_ready = 1 in IDLE; o_ready = i_ready in DONE; o_ready = 0 in BUSY and whenever i_rst is 1.
REQ-019 IDLE: on accept -> BUSY with beat counter = 0; otherwise stay IDLE.
REQ-020 BUSY: each cycle multiply captured elements [cnt*n_mul .. cnt*n_mul+n_mul-1] on the n_mul multipliers and register the products into the matching o_prd slice; counter increments by 1.
REQ-021 BUSY: on the cycle with cnt = BEATS-1, go to DONE; counter wraps to 0.
REQ-022 DONE: o_valid = 1; o_prd held constant while i_ready = 0.
REQ-023 DONE with i_ready = 1 and i_valid = 0 -> IDLE; with i_ready = 1 and i_valid = 1 -> accept new vector and go directly to BUSY (back-to-back).
REQ-024 Latency: accept edge at cycle 0 -> o_valid = 1 from cycle BEATS+1 (cycle 5 with defaults); sustained throughput one vector per BEATS+1 cycles.
REQ-025 Signed mode: each product = sign-extended A[i] x sign-extended B[i], exact two's-complement result sign-extended to prd_width.
REQ-026 Unsigned mode: each product = zero-extended A[i] x zero-extended B[i], exact result zero-extended to prd_width.
REQ-027 Mode is per vector: captured i_signed applies to all beats of that vector; changes of i_signed, i_vec_a, i_vec_b outside accept have no effect.
REQ-028 o_prd slices not yet written for the current vector SHALL NOT be visible as valid data; o_valid = 0 throughout BUSY.
REQ-029 n_mul = length: BEATS = 1, latency 2 cycles; same FSM applies.

Reset
REQ-030 i_rst = 1 at an edge: state -> IDLE, counter -> 0, o_valid -> 0, all o_prd elements -> 0, captured operands and mode -> 0.
REQ-031 Reset in BUSY or DONE aborts the vector; no o_valid pulse is produced for it.
REQ-032 First accept possible on the first edge with i_rst = 0.

Verification
REQ-033 Defaults, signed, A[i]=i-16, B[i]=3, i_ready=1 -> o_valid at cycle 5 for one cycle, o_prd[i]=3*(i-16) (o_prd[0]=0xFFD0), o_ready back to 1 at cycle 6.
REQ-034 Corners: signed A=B=all 0x80 -> all 0x4000; unsigned A=B=all 0xFF -> all 0xFE01; signed 0x80 x 0x7F -> 0xC080.
REQ-035 Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_prd stable, o_ready=0; i_ready=1 with i_valid=1 -> next vector accepted that edge, next o_valid 5 cycles later.
REQ-036 Operand/mode toggled every cycle during BUSY -> results match values captured at accept.
REQ-037 i_rst asserted at cycle 2 of BUSY -> o_valid never asserted for that vector, o_prd all 0, o_ready=1 the cycle after reset deasserts.
REQ-038 Random streams with random i_valid/i_ready over n_mul in {1,8,32} -> every accepted vector produces exactly one matching output, in order, none dropped or duplicated.

Source files
------------

// File: rtl/vec_mul_seq.sv
// -----------------------------------------------------------------------------
// vec_mul_seq
//
// Sequential elementwise vector multiplier. It accepts one pair of operand
// vectors (A, B) and multiplies them element by element on n_mul physical
// multipliers. A full vector therefore takes BEATS = length / n_mul cycles. The
// complete product vector is then offered to the downstream consumer.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Input side : i_valid / o_ready. The operands and the mode bit are captured
//                only on the accepting edge. They may change freely at any
//                other time.
//   Output side: o_valid / i_ready. o_prd is held stable while o_valid = 1
//                and i_ready = 0.
//   o_ready is combinational. It is 1 in IDLE, and it follows i_ready in DONE,
//   so a new vector can be accepted on the same edge that retires the
//   previous result.
//
// Ports:
//   i_clk     in   1                   clock, rising edge
//   i_rst     in   1                   synchronous active-high reset
//   i_valid   in   1                   input vector offered
//   o_ready   out  1                   block can accept an input vector
//   i_vec_a   in   length*bit_width    operand vector A, element i at [i*bit_width +: bit_width]
//   i_vec_b   in   length*bit_width    operand vector B, same packing as A
//   i_signed  in   1                   1: two's-complement operands, 0: unsigned
//   o_valid   out  1                   product vector available
//   i_ready   in   1                   downstream accepts product vector
//   o_prd     out  length*prd_width    products, element i at [i*prd_width +: prd_width]
// -----------------------------------------------------------------------------
module vec_mul_seq #(
    parameter int bit_width = 8,
    parameter int length    = 32,
    parameter int n_mul     = 8,
    parameter int prd_width = 2 * bit_width
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [length*bit_width-1:0] i_vec_a,
    input  logic [length*bit_width-1:0] i_vec_b,
    input  logic                        i_signed,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [length*prd_width-1:0] o_prd
);

    // Multiply cycles per vector.
    localparam int BEATS = length / n_mul;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Extra bits above an operand needed to reach the product width.
    localparam int EXT_W = prd_width - bit_width;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (n_mul < 1 || length < n_mul || (length % n_mul) != 0) begin : g_bad_n_mul
            $error("vec_mul_seq: length must be a positive integer multiple of n_mul");
        end
        if (prd_width < 2 * bit_width) begin : g_bad_prd_width
            $error("vec_mul_seq: prd_width must be at least 2*bit_width");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [length*bit_width-1:0] a_q, a_d;
    logic [length*bit_width-1:0] b_q, b_d;
    logic                        sgn_q, sgn_d;
    logic [length*prd_width-1:0] prd_q, prd_d;

    // Handshake and beat control
    logic accept;
    logic last_beat;

    // Per-lane datapath
    logic [bit_width-1:0] op_a     [n_mul];
    logic [bit_width-1:0] op_b     [n_mul];
    logic [prd_width-1:0] lane_prd [n_mul];

    assign accept    = i_valid & o_ready;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // -------------------------------------------------------------------------
    // Lane operand selection and multiplication
    // -------------------------------------------------------------------------
    // Lane j works on element cnt*n_mul + j of the captured vectors. Each
    // operand is extended to prd_width bits first, with sign extension in
    // signed mode and zero extension otherwise. A prd_width x prd_width
    // multiply keeps only the low prd_width bits of the result. Because
    // prd_width >= 2*bit_width, those low bits are the exact product already
    // extended to prd_width, and this holds for both modes.
    always_comb begin
        for (int j = 0; j < n_mul; j++) begin
            op_a[j]     = a_q[(int'(cnt_q) * n_mul + j) * bit_width +: bit_width];
            op_b[j]     = b_q[(int'(cnt_q) * n_mul + j) * bit_width +: bit_width];
            lane_prd[j] = {{EXT_W{sgn_q & op_a[j][bit_width-1]}}, op_a[j]}
                        * {{EXT_W{sgn_q & op_b[j][bit_width-1]}}, op_b[j]};
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            prd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            prd_q   <= prd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath-update logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        prd_d   = prd_q;

        // An accept can only occur in IDLE or DONE, because o_ready is 0 in
        // BUSY. Capturing here covers both the IDLE entry and the
        // back-to-back entry from DONE.
        if (accept) begin
            a_d   = i_vec_a;
            b_d   = i_vec_b;
            sgn_d = i_signed;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end

            ST_BUSY: begin
                for (int j = 0; j < n_mul; j++) begin
                    prd_d[(int'(cnt_q) * n_mul + j) * prd_width +: prd_width] = lane_prd[j];
                end
                if (last_beat) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // The result retires when i_ready is 1. In that same cycle,
                // a waiting input vector (if any) is taken in.
                if (i_ready) begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // o_ready is forced low while reset is high, so no accept can overlap a
    // reset edge.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        if (!i_rst) begin
            case (state_q)
                ST_IDLE: o_ready = 1'b1;
                ST_DONE: o_ready = i_ready;
                default: o_ready = 1'b0;
            endcase
        end
        o_valid = (state_q == ST_DONE);
    end

    assign o_prd = prd_q;

endmodule

// File: tb/tb_vec_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_vec_mul_seq
//
// Three instances of vec_mul_seq share every input. The first uses
// n_mul = 8 (BEATS = 4), the second n_mul = 1 (BEATS = 32) and the third
// n_mul = 32 (BEATS = 1).
// The directed scenarios check cycle timing on the n_mul = 8 instance. The
// random stream scenario checks ordering and completeness on all three
// instances. Expected products come from ref_prd, which computes each element
// with plain integer arithmetic from the operand values and the mode.
// -----------------------------------------------------------------------------
module tb_vec_mul_seq;

    localparam int BW    = 8;
    localparam int LEN   = 32;
    localparam int PW    = 16;
    localparam int VW    = LEN * BW;
    localparam int FW    = LEN * PW;
    localparam int BEATS = 4;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT signals
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      = 1'b1;
    logic          i_valid  = 1'b0;
    logic          i_ready  = 1'b0;
    logic          i_signed = 1'b0;
    logic [VW-1:0] i_vec_a  = '0;
    logic [VW-1:0] i_vec_b  = '0;

    logic          o_ready8,  o_valid8;
    logic [FW-1:0] o_prd8;
    logic          o_ready1,  o_valid1;
    logic [FW-1:0] o_prd1;
    logic          o_ready32, o_valid32;
    logic [FW-1:0] o_prd32;

    int vectors     = 0;
    int miscompares = 0;

    vec_mul_seq #(.bit_width(BW), .length(LEN), .n_mul(8), .prd_width(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready8),
        .i_vec_a(i_vec_a), .i_vec_b(i_vec_b), .i_signed(i_signed),
        .o_valid(o_valid8), .i_ready(i_ready), .o_prd(o_prd8)
    );

    vec_mul_seq #(.bit_width(BW), .length(LEN), .n_mul(1), .prd_width(PW)) dut_n1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready1),
        .i_vec_a(i_vec_a), .i_vec_b(i_vec_b), .i_signed(i_signed),
        .o_valid(o_valid1), .i_ready(i_ready), .o_prd(o_prd1)
    );

    vec_mul_seq #(.bit_width(BW), .length(LEN), .n_mul(32), .prd_width(PW)) dut_n32 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready32),
        .i_vec_a(i_vec_a), .i_vec_b(i_vec_b), .i_signed(i_signed),
        .o_valid(o_valid32), .i_ready(i_ready), .o_prd(o_prd32)
    );

    // -------------------------------------------------------------------------
    // Reference model and stimulus helpers
    // -------------------------------------------------------------------------
    function automatic logic [FW-1:0] ref_prd(input logic [VW-1:0] a,
                                              input logic [VW-1:0] b,
                                              input logic          sgn);
        logic [FW-1:0]        r;
        logic signed [BW-1:0] sa, sb;
        logic [BW-1:0]        ua, ub;
        longint               x, y;
        r = '0;
        for (int i = 0; i < LEN; i++) begin
            ua = a[i*BW +: BW];
            ub = b[i*BW +: BW];
            sa = ua;
            sb = ub;
            if (sgn) begin
                x = longint'(sa);
                y = longint'(sb);
            end else begin
                x = longint'(ua);
                y = longint'(ub);
            end
            r[i*PW +: PW] = PW'(x * y);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < LEN; i++) v[i*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [BW-1:0] e);
        logic [VW-1:0] v;
        for (int i = 0; i < LEN; i++) v[i*BW +: BW] = e;
        return v;
    endfunction

    function automatic logic [FW-1:0] fill_prd(input logic [PW-1:0] e);
        logic [FW-1:0] v;
        for (int i = 0; i < LEN; i++) v[i*PW +: PW] = e;
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Stream scoreboard (all three instances). It samples on the falling
    // edge, where it sees the values the next rising edge will act on.
    // -------------------------------------------------------------------------
    bit            mon_en = 1'b0;
    logic [FW-1:0] exp_q1[$];
    logic [FW-1:0] exp_q8[$];
    logic [FW-1:0] exp_q32[$];
    logic [FW-1:0] mon_exp;
    int            acc1 = 0, acc8 = 0, acc32 = 0;
    int            out1 = 0, out8 = 0, out32 = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (o_valid1 && i_ready) begin
                vectors++;
                out1++;
                if (exp_q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_n1 extra output: got %h want none", o_prd1);
                end else begin
                    mon_exp = exp_q1.pop_front();
                    if (o_prd1 !== mon_exp) begin
                        miscompares++;
                        $display("FAIL stream_n1 prd: got %h want %h", o_prd1, mon_exp);
                    end
                end
            end
            if (i_valid && o_ready1) begin
                exp_q1.push_back(ref_prd(i_vec_a, i_vec_b, i_signed));
                acc1++;
            end

            if (o_valid8 && i_ready) begin
                vectors++;
                out8++;
                if (exp_q8.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_n8 extra output: got %h want none", o_prd8);
                end else begin
                    mon_exp = exp_q8.pop_front();
                    if (o_prd8 !== mon_exp) begin
                        miscompares++;
                        $display("FAIL stream_n8 prd: got %h want %h", o_prd8, mon_exp);
                    end
                end
            end
            if (i_valid && o_ready8) begin
                exp_q8.push_back(ref_prd(i_vec_a, i_vec_b, i_signed));
                acc8++;
            end

            if (o_valid32 && i_ready) begin
                vectors++;
                out32++;
                if (exp_q32.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_n32 extra output: got %h want none", o_prd32);
                end else begin
                    mon_exp = exp_q32.pop_front();
                    if (o_prd32 !== mon_exp) begin
                        miscompares++;
                        $display("FAIL stream_n32 prd: got %h want %h", o_prd32, mon_exp);
                    end
                end
            end
            if (i_valid && o_ready32) begin
                exp_q32.push_back(ref_prd(i_vec_a, i_vec_b, i_signed));
                acc32++;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver: one vector through the n_mul = 8 instance with i_ready = 1.
    // If scramble is set, the inputs (including i_valid and the mode) are
    // randomised during BUSY.
    // -------------------------------------------------------------------------
    task automatic run_vector(input logic [VW-1:0] a, input logic [VW-1:0] b,
                              input logic sgn, input logic [FW-1:0] exp,
                              input bit scramble, input string name);
        i_vec_a  = a;
        i_vec_b  = b;
        i_signed = sgn;
        i_valid  = 1'b1;
        i_ready  = 1'b1;
        vectors++;
        if (o_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, o_ready8);
        end
        step();
        i_valid = 1'b0;
        for (int c = 1; c <= BEATS; c++) begin
            vectors++;
            if (o_valid8 !== 1'b0 || o_ready8 !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy_cycle%0d: got valid=%b ready=%b want 0 0",
                         name, c, o_valid8, o_ready8);
            end
            if (scramble) begin
                i_vec_a  = rand_vec();
                i_vec_b  = rand_vec();
                i_signed = ~i_signed;
                i_valid  = 1'($urandom_range(0, 1));
            end
            step();
        end
        i_valid = 1'b0;
        vectors++;
        if (o_valid8 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s valid_at_cycle%0d: got %b want 1", name, BEATS + 1, o_valid8);
        end
        vectors++;
        if (o_prd8 !== exp) begin
            miscompares++;
            $display("FAIL %s prd: got %h want %h", name, o_prd8, exp);
        end
        step();
        vectors++;
        if (o_valid8 !== 1'b0 || o_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after_done: got valid=%b ready=%b want 0 1", name, o_valid8, o_ready8);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        step();
        vectors++;
        if (o_ready8 !== 1'b0 || o_ready1 !== 1'b0 || o_ready32 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset ready_in_reset: got %b%b%b want 000", o_ready8, o_ready1, o_ready32);
        end
        vectors++;
        if (o_valid8 !== 1'b0 || o_valid1 !== 1'b0 || o_valid32 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset valid: got %b%b%b want 000", o_valid8, o_valid1, o_valid32);
        end
        vectors++;
        if (o_prd8 !== '0 || o_prd1 !== '0 || o_prd32 !== '0) begin
            miscompares++;
            $display("FAIL reset prd: got %h want 0", o_prd8);
        end
        rst     = 1'b0;
        i_valid = 1'b0;
        #1;
        vectors++;
        if (o_ready8 !== 1'b1 || o_ready1 !== 1'b1 || o_ready32 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset ready_after_release: got %b%b%b want 111", o_ready8, o_ready1, o_ready32);
        end
    endtask

    task automatic test_basic();
        logic [VW-1:0] a;
        logic [FW-1:0] e;
        for (int i = 0; i < LEN; i++) begin
            a[i*BW +: BW] = BW'(i - 16);
            e[i*PW +: PW] = PW'(3 * (i - 16));
        end
        run_vector(a, fill_vec(8'd3), 1'b1, e, 1'b0, "basic_signed");
    endtask

    task automatic test_corners();
        run_vector(fill_vec(8'h80), fill_vec(8'h80), 1'b1, fill_prd(16'h4000), 1'b0, "corner_s80x80");
        run_vector(fill_vec(8'hFF), fill_vec(8'hFF), 1'b0, fill_prd(16'hFE01), 1'b0, "corner_uFFxFF");
        run_vector(fill_vec(8'h80), fill_vec(8'h7F), 1'b1, fill_prd(16'hC080), 1'b0, "corner_s80x7F");
        run_vector(fill_vec(8'hFF), fill_vec(8'hFF), 1'b1, fill_prd(16'h0001), 1'b0, "corner_sFFxFF");
    endtask

    task automatic test_random();
        logic [VW-1:0] a, b;
        logic          s;
        for (int k = 0; k < 6; k++) begin
            a = rand_vec();
            b = rand_vec();
            s = 1'(k % 2);
            run_vector(a, b, s, ref_prd(a, b, s), 1'b0, "random");
        end
    endtask

    task automatic test_mode_toggle();
        logic [VW-1:0] a, b;
        logic          s;
        for (int k = 0; k < 4; k++) begin
            a = rand_vec();
            b = rand_vec();
            s = 1'(k % 2);
            run_vector(a, b, s, ref_prd(a, b, s), 1'b1, "mode_toggle");
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] a1, b1, a2, b2;
        logic          s1, s2;
        logic [FW-1:0] e1, e2;
        a1 = rand_vec(); b1 = rand_vec(); s1 = 1'b1;
        a2 = rand_vec(); b2 = rand_vec(); s2 = 1'b0;
        e1 = ref_prd(a1, b1, s1);
        e2 = ref_prd(a2, b2, s2);
        i_vec_a = a1; i_vec_b = b1; i_signed = s1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (BEATS) step();
        // DONE: the second vector waits with i_valid high while output is stalled.
        i_vec_a = a2; i_vec_b = b2; i_signed = s2;
        i_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (o_valid8 !== 1'b1 || o_ready8 !== 1'b0 || o_prd8 !== e1) begin
                miscompares++;
                $display("FAIL backpressure stall%0d: got valid=%b ready=%b prd=%h want 1 0 %h",
                         k, o_valid8, o_ready8, o_prd8, e1);
            end
            step();
        end
        i_ready = 1'b1;
        #1;
        vectors++;
        if (o_ready8 !== 1'b1 || o_valid8 !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure release: got ready=%b valid=%b want 1 1", o_ready8, o_valid8);
        end
        step();
        i_valid = 1'b0;
        for (int c = 1; c <= BEATS; c++) begin
            vectors++;
            if (o_valid8 !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure second_busy%0d: got %b want 0", c, o_valid8);
            end
            step();
        end
        vectors++;
        if (o_valid8 !== 1'b1 || o_prd8 !== e2) begin
            miscompares++;
            $display("FAIL backpressure second_result: got valid=%b prd=%h want 1 %h", o_valid8, o_prd8, e2);
        end
        step();
    endtask

    task automatic test_reset_abort();
        logic [VW-1:0] a, b;
        a = rand_vec() | fill_vec(8'h01);
        b = rand_vec() | fill_vec(8'h01);
        i_vec_a = a; i_vec_b = b; i_signed = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if (o_ready8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort ready_during_reset: got %b want 0", o_ready8);
        end
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (o_ready8 !== 1'b1 || o_valid8 !== 1'b0 || o_prd8 !== '0) begin
            miscompares++;
            $display("FAIL reset_abort after: got ready=%b valid=%b prd=%h want 1 0 0",
                     o_ready8, o_valid8, o_prd8);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (o_valid8 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_abort no_valid%0d: got %b want 0", k, o_valid8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] va [4];
        logic [VW-1:0] vb [4];
        logic          vs [4];
        logic [FW-1:0] ve [4];
        for (int k = 0; k < 4; k++) begin
            va[k] = rand_vec();
            vb[k] = rand_vec();
            vs[k] = 1'($urandom_range(0, 1));
            ve[k] = ref_prd(va[k], vb[k], vs[k]);
        end
        i_vec_a = va[0]; i_vec_b = vb[0]; i_signed = vs[0];
        i_valid = 1'b1;
        i_ready = 1'b1;
        vectors++;
        if (o_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back first_ready: got %b want 1", o_ready8);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                i_vec_a = va[k+1]; i_vec_b = vb[k+1]; i_signed = vs[k+1];
            end else begin
                i_valid = 1'b0;
            end
            for (int c = 1; c <= BEATS; c++) begin
                vectors++;
                if (o_valid8 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL back_to_back v%0d busy%0d: got %b want 0", k, c, o_valid8);
                end
                step();
            end
            vectors++;
            if (o_valid8 !== 1'b1 || o_prd8 !== ve[k] || o_ready8 !== 1'b1) begin
                miscompares++;
                $display("FAIL back_to_back v%0d result: got valid=%b ready=%b prd=%h want 1 1 %h",
                         k, o_valid8, o_ready8, o_prd8, ve[k]);
            end
            step();
        end
        vectors++;
        if (o_valid8 !== 1'b0 || o_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back idle: got valid=%b ready=%b want 0 1", o_valid8, o_ready8);
        end
    endtask

    task automatic test_random_stream();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q1.delete();
        exp_q8.delete();
        exp_q32.delete();
        acc1 = 0; acc8 = 0; acc32 = 0;
        out1 = 0; out8 = 0; out32 = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_ready  = ($urandom_range(0, 3) != 0);
            i_vec_a  = rand_vec();
            i_vec_b  = rand_vec();
            i_signed = 1'($urandom_range(0, 1));
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (40) step();
        mon_en = 1'b0;
        vectors++;
        if (exp_q1.size() != 0 || exp_q8.size() != 0 || exp_q32.size() != 0) begin
            miscompares++;
            $display("FAIL stream pending: got %0d/%0d/%0d want 0/0/0",
                     exp_q1.size(), exp_q8.size(), exp_q32.size());
        end
        vectors++;
        if (acc1 != out1 || acc8 != out8 || acc32 != out32) begin
            miscompares++;
            $display("FAIL stream counts: got out %0d/%0d/%0d want %0d/%0d/%0d",
                     out1, out8, out32, acc1, acc8, acc32);
        end
        vectors++;
        if (acc1 < 5 || acc8 < 20 || acc32 < 50) begin
            miscompares++;
            $display("FAIL stream activity: got accepts %0d/%0d/%0d want >=5/20/50", acc1, acc8, acc32);
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_mode_toggle();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
